// File: rtl/ysyx_040750_hazard_ctrl.sv
// ID-stage hazard controller: operand forwarding select, load-use/multicycle/serialising stalls,
// multicycle countdown scoreboard, and saturating per-cause stall-cycle counters.
module ysyx_040750_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 6,
    parameter int CNT_W      = 32
) (
    input  logic                          I_sys_clk,
    input  logic                          I_rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] I_src_addr,
    input  logic [NUM_SRC-1:0]            I_src_en,
    input  logic                          I_ID_valid,
    input  logic                          I_ID_mc,
    input  logic [REG_ADDR_W-1:0]         I_EX_rd_addr,
    input  logic [REG_ADDR_W-1:0]         I_MEM_rd_addr,
    input  logic [REG_ADDR_W-1:0]         I_WB_rd_addr,
    input  logic                          I_EX_valid,
    input  logic                          I_MEM_valid,
    input  logic                          I_WB_valid,
    input  logic                          I_EX_mem_rd_en,
    input  logic                          I_MEM_mem_rd_en,
    input  logic                          I_EX_intr,
    input  logic                          I_WB_intr,
    input  logic                          I_EX_mc_start,
    input  logic [LAT_W-1:0]              I_EX_mc_lat,
    input  logic                          I_flush,
    output logic [2*NUM_SRC-1:0]          O_fwd_sel,
    output logic                          O_ID_stall,
    output logic                          O_mc_busy,
    output logic [CNT_W-1:0]              O_cnt_load,
    output logic [CNT_W-1:0]              O_cnt_mc,
    output logic [CNT_W-1:0]              O_cnt_intr
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                  state, state_next;
    logic [LAT_W-1:0]        mc_cnt;
    logic [REG_ADDR_W-1:0]   mc_rd;
    logic                    load_stall, mc_hit, mc_stall, intr_stall;

    always_comb begin
        O_fwd_sel  = '0;
        load_stall = 1'b0;
        mc_hit     = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            logic [REG_ADDR_W-1:0] src;
            logic                  live, hit_ex, hit_mem, hit_wb;
            src     = I_src_addr[k*REG_ADDR_W +: REG_ADDR_W];
            live    = I_src_en[k] && (src != '0);
            hit_ex  = live && I_EX_valid  && (src == I_EX_rd_addr);
            hit_mem = live && I_MEM_valid && (src == I_MEM_rd_addr);
            hit_wb  = live && I_WB_valid  && (src == I_WB_rd_addr);
            if (hit_ex)
                O_fwd_sel[2*k +: 2] = 2'd1;
            else if (hit_mem)
                O_fwd_sel[2*k +: 2] = 2'd2;
            else if (hit_wb)
                O_fwd_sel[2*k +: 2] = 2'd3;
            if ((hit_ex && I_EX_mem_rd_en) || (hit_mem && I_MEM_mem_rd_en))
                load_stall = 1'b1;
            if (live && (src == mc_rd))
                mc_hit = 1'b1;
        end
    end

    assign O_mc_busy  = (mc_cnt != '0);
    assign mc_stall   = O_mc_busy && (mc_hit || I_ID_mc);
    assign intr_stall = (state == DRAIN) || (I_EX_valid && I_EX_intr);
    assign O_ID_stall = I_ID_valid && (load_stall || mc_stall || intr_stall);

    // Flush dominates; otherwise exit is only evaluated from DRAIN and entry only from RUN.
    always_comb begin
        state_next = state;
        if (I_flush)
            state_next = RUN;
        else if (state == RUN) begin
            if (I_EX_valid && I_EX_intr)
                state_next = DRAIN;
        end else begin
            if (I_WB_valid && I_WB_intr)
                state_next = RUN;
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            mc_cnt <= '0;
            mc_rd  <= '0;
        end else if (I_flush) begin
            mc_cnt <= '0;
        end else if (I_EX_mc_start && I_EX_valid && !O_mc_busy && (I_EX_mc_lat != '0)) begin
            mc_cnt <= I_EX_mc_lat;
            mc_rd  <= I_EX_rd_addr;
        end else if (O_mc_busy) begin
            mc_cnt <= mc_cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            O_cnt_load <= '0;
            O_cnt_mc   <= '0;
            O_cnt_intr <= '0;
        end else if (O_ID_stall) begin
            if (intr_stall) begin
                if (O_cnt_intr != '1)
                    O_cnt_intr <= O_cnt_intr + CNT_W'(1);
            end else if (mc_stall) begin
                if (O_cnt_mc != '1)
                    O_cnt_mc <= O_cnt_mc + CNT_W'(1);
            end else begin
                if (O_cnt_load != '1)
                    O_cnt_load <= O_cnt_load + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040750_hazard_ctrl.sv
// Scoreboard bench for ysyx_040750_hazard_ctrl (CNT_W=4 so counter saturation is reachable).
module tb_ysyx_040750_hazard_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int LW = 6;
    localparam int CW = 4;

    logic           clk;
    logic           rst;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]  src_en;
    logic           id_valid, id_mc;
    logic [AW-1:0]  ex_rd, mem_rd, wb_rd;
    logic           ex_valid, mem_valid, wb_valid;
    logic           ex_ld, mem_ld, ex_intr, wb_intr, mc_start, flush;
    logic [LW-1:0]  mc_lat;
    logic [2*NS-1:0] fwd_sel;
    logic           id_stall, mc_busy;
    logic [CW-1:0]  cnt_load, cnt_mc, cnt_intr;

    ysyx_040750_hazard_ctrl #(
        .REG_ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW), .CNT_W(CW)
    ) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_src_addr(src_addr), .I_src_en(src_en),
        .I_ID_valid(id_valid), .I_ID_mc(id_mc),
        .I_EX_rd_addr(ex_rd), .I_MEM_rd_addr(mem_rd), .I_WB_rd_addr(wb_rd),
        .I_EX_valid(ex_valid), .I_MEM_valid(mem_valid), .I_WB_valid(wb_valid),
        .I_EX_mem_rd_en(ex_ld), .I_MEM_mem_rd_en(mem_ld),
        .I_EX_intr(ex_intr), .I_WB_intr(wb_intr),
        .I_EX_mc_start(mc_start), .I_EX_mc_lat(mc_lat), .I_flush(flush),
        .O_fwd_sel(fwd_sel), .O_ID_stall(id_stall), .O_mc_busy(mc_busy),
        .O_cnt_load(cnt_load), .O_cnt_mc(cnt_mc), .O_cnt_intr(cnt_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*NS-1:0] fwd;
        logic            stall;
        logic            busy;
        logic [CW-1:0]   cl, cm, ci;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic          m_drain;
    logic [LW-1:0] m_cnt;
    logic [AW-1:0] m_rd;
    logic [CW-1:0] m_cl, m_cm, m_ci;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [AW-1:0] a, input logic en);
        if (!en || a == '0) return 2'd0;
        if (ex_valid && a == ex_rd) return 2'd1;
        if (mem_valid && a == mem_rd) return 2'd2;
        if (wb_valid && a == wb_rd) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic model_reset();
        m_drain = 1'b0; m_cnt = '0; m_rd = '0; m_cl = '0; m_cm = '0; m_ci = '0;
    endtask

    task automatic idle();
        src_addr = '0; src_en = '0; id_valid = 0; id_mc = 0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_valid = 0; mem_valid = 0; wb_valid = 0;
        ex_ld = 0; mem_ld = 0; ex_intr = 0; wb_intr = 0;
        mc_start = 0; mc_lat = '0; flush = 0;
    endtask

    // One clock: model predicts, pushes, DUT sampled at negedge, model advances at posedge.
    task automatic cycle();
        exp_t e, g;
        logic c_load, c_mc, c_intr, busy;
        logic [AW-1:0] a;
        c_load = 0; c_mc = 0;
        busy = (m_cnt != 0);
        for (int k = 0; k < NS; k++) begin
            a = src_addr[k*AW +: AW];
            e.fwd[2*k +: 2] = fsel(a, src_en[k]);
            if (src_en[k] && a != 0) begin
                if (ex_ld && ex_valid && a == ex_rd) c_load = 1;
                if (mem_ld && mem_valid && a == mem_rd) c_load = 1;
                if (busy && m_rd != 0 && a == m_rd) c_mc = 1;
            end
        end
        if (busy && id_mc) c_mc = 1;
        c_intr = m_drain || (ex_valid && ex_intr);
        e.stall = id_valid && (c_load || c_mc || c_intr);
        e.busy = busy;
        e.cl = m_cl; e.cm = m_cm; e.ci = m_ci;
        sb.push_back(e);

        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            check("fwd_sel", fwd_sel, g.fwd);
            check("id_stall", id_stall, g.stall);
            check("mc_busy", mc_busy, g.busy);
            check("cnt_load", cnt_load, g.cl);
            check("cnt_mc", cnt_mc, g.cm);
            check("cnt_intr", cnt_intr, g.ci);
        end

        @(posedge clk);
        if (e.stall) begin
            if (c_intr) m_ci = sat_inc(m_ci);
            else if (c_mc) m_cm = sat_inc(m_cm);
            else m_cl = sat_inc(m_cl);
        end
        if (flush) begin
            m_drain = 0; m_cnt = 0;
        end else begin
            if (!m_drain && ex_valid && ex_intr) m_drain = 1;
            else if (m_drain && wb_valid && wb_intr) m_drain = 0;
            if (mc_start && ex_valid && !busy && mc_lat != 0) begin
                m_cnt = mc_lat; m_rd = ex_rd;
            end else if (busy) m_cnt = m_cnt - 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", mc_busy, 0);
        check("rst_cnt_load", cnt_load, 0);
        check("rst_cnt_mc", cnt_mc, 0);
        check("rst_cnt_intr", cnt_intr, 0);
        @(negedge clk) rst = 0;
        @(posedge clk) #1;

        // forwarding priority
        id_valid = 1; src_en = 2'b11; src_addr = {5'd0, 5'd5};
        ex_rd = 5; mem_rd = 5; wb_rd = 5; ex_valid = 1; mem_valid = 1; wb_valid = 1;
        #1;
        check("fwd_prio", fwd_sel, 4'b0001);
        check("fwd_nostall", id_stall, 0);
        cycle();
        ex_valid = 0; cycle();
        mem_valid = 0; cycle();

        // load-use through EX, MEM, then WB forwarding
        idle(); id_valid = 1; src_en = 2'b10; src_addr = {5'd7, 5'd0};
        ex_rd = 7; ex_valid = 1; ex_ld = 1; cycle();
        idle(); id_valid = 1; src_en = 2'b10; src_addr = {5'd7, 5'd0};
        mem_rd = 7; mem_valid = 1; mem_ld = 1; cycle();
        idle(); id_valid = 1; src_en = 2'b10; src_addr = {5'd7, 5'd0};
        wb_rd = 7; wb_valid = 1;
        #1;
        check("wb_fwd", fwd_sel, 4'b1100);
        cycle();
        check("cnt_load_2", cnt_load, 2);

        // multicycle: dependent source stalls for the full latency
        idle(); ex_valid = 1; mc_start = 1; mc_lat = 4; ex_rd = 9; cycle();
        idle(); id_valid = 1; src_en = 2'b01; src_addr = {5'd0, 5'd9};
        repeat (5) cycle();
        check("cnt_mc_4", cnt_mc, 4);

        // multicycle ID op stalls, flush in busy cycle 2
        idle(); ex_valid = 1; mc_start = 1; mc_lat = 4; ex_rd = 9; cycle();
        idle(); id_valid = 1; id_mc = 1; cycle();
        flush = 1; cycle();
        flush = 0; cycle();
        check("flush_busy", mc_busy, 0);
        check("cnt_mc_6", cnt_mc, 6);

        // drain: entry, hold (with overlapping load-use), exit
        idle(); id_valid = 1; ex_valid = 1; ex_intr = 1; cycle();
        idle(); id_valid = 1; cycle();
        src_en = 2'b10; src_addr = {5'd7, 5'd0}; mem_rd = 7; mem_valid = 1; mem_ld = 1; cycle();
        idle(); id_valid = 1; wb_valid = 1; wb_intr = 1; cycle();
        idle(); id_valid = 1; cycle();
        check("cnt_intr_4", cnt_intr, 4);
        check("cnt_load_hold", cnt_load, 2);

        // saturation
        idle(); id_valid = 1; ex_valid = 1; ex_intr = 1;
        repeat (20) cycle();
        check("cnt_intr_sat", cnt_intr, 15);

        // busy while in DRAIN, then asynchronous reset between edges
        idle(); id_valid = 1; ex_valid = 1; mc_start = 1; mc_lat = 10; ex_rd = 3; cycle();
        idle(); id_valid = 1; src_en = 2'b01; src_addr = {5'd0, 5'd3};
        #2;
        check("pre_rst_stall", id_stall, 1);
        check("pre_rst_busy", mc_busy, 1);
        rst = 1;
        #1;
        check("arst_busy", mc_busy, 0);
        check("arst_stall", id_stall, 0);
        check("arst_cnt_load", cnt_load, 0);
        check("arst_cnt_mc", cnt_mc, 0);
        check("arst_cnt_intr", cnt_intr, 0);
        @(negedge clk) rst = 0;
        @(posedge clk) #1;
        model_reset();
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
